// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator store buffer: default sizes,
// drain-FSM states and the store-entry layout.
package ac_pkg;

  localparam int WORD_SIZE  = 24;
  localparam int ADDR_WIDTH = 16;
  localparam int DEPTH      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } store_entry_t;

endpackage

// File: rtl/ac_store_fifo.sv
// Store-entry FIFO: storage, pointers, occupancy count, registered full/empty
// flags and a registered head entry that is valid whenever empty=0.
module ac_store_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [W-1:0]  head_r;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Acceptance is decided on the registered flags, so a push while full is dropped
  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next read pointer and next occupancy
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry storage; contents need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, count, flags and head register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      head_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == CW'(0));
      // A push landing in the new head slot bypasses the array
      if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
        head_r <= wr_data;
      end else begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end
    end
  end

  assign head  = head_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/ac_store_buffer.sv
// Write-back buffer between the AC register and data memory: queues store
// commands and drains them over a req/ack handshake with a one-cycle gap.
module ac_store_buffer #(
  parameter int WORD_SIZE  = ac_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = ac_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ac_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_en,
  input  logic [WORD_SIZE-1:0]  ac_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ack
);

  import ac_pkg::*;

  localparam int EW = ADDR_WIDTH + WORD_SIZE;

  drain_state_e  state_r;
  drain_state_e  state_nxt_s;
  logic          req_r;
  logic          ovf_r;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [EW-1:0] head_s;

  // Ack only counts while a request is actually on the bus
  assign pop_s = req_r && mem_ack;

  ac_store_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (store_en),
    .pop     (pop_s),
    .wr_data ({addr_in, ac_in}),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Drain FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_nxt_s = REQ;
        else          state_nxt_s = IDLE;
      end
      REQ: begin
        if (mem_ack) state_nxt_s = GAP;
        else         state_nxt_s = REQ;
      end
      GAP: begin
        if (!empty_s) state_nxt_s = REQ;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, registered request and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == REQ);
      ovf_r   <= ovf_r | (store_en & full_s);
    end
  end

  // Head entry is registered in the FIFO and cannot change while requesting
  assign mem_addr     = head_s[EW-1:WORD_SIZE];
  assign mem_wdata    = head_s[WORD_SIZE-1:0];
  assign mem_req      = req_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign overflow_err = ovf_r;

endmodule

// File: tb/tb_ac_store_buffer.sv
// Directed bench for ac_store_buffer: a queue-level model checked every cycle
// plus literal expectations for each scenario.
module tb_ac_store_buffer;
  import ac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store_en = 1'b0;
  logic [23:0] ac_in = 24'h0;
  logic [15:0] addr_in = 16'h0;
  logic        mem_ack = 1'b0;
  logic        full, empty, overflow_err, mem_req;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  store_entry_t mq[$];
  logic [23:0]  drained[$];
  bit           m_req = 1'b0;
  bit           m_ovf = 1'b0;
  logic [6:0]   pat;

  ac_store_buffer dut (
    .clk(clk), .rst(rst), .store_en(store_en), .ac_in(ac_in), .addr_in(addr_in),
    .full(full), .empty(empty), .overflow_err(overflow_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO of entries; a request is raised after any low cycle with entries waiting
  always @(posedge clk) begin
    int  n_before;
    bit  was_full;
    store_entry_t e;
    if (rst) begin
      mq.delete();
      m_req = 1'b0;
      m_ovf = 1'b0;
    end else begin
      n_before = mq.size();
      was_full = (n_before == DEPTH);
      if (store_en && was_full) m_ovf = 1'b1;
      if (m_req && mem_ack) begin
        drained.push_back(mq[0].data);
        void'(mq.pop_front());
      end
      if (store_en && !was_full) begin
        e.addr = addr_in;
        e.data = ac_in;
        mq.push_back(e);
      end
      if (m_req) m_req = !mem_ack;
      else       m_req = (n_before > 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("overflow_err", overflow_err, m_ovf);
      chk("mem_req", mem_req, m_req);
      if (m_req && mq.size() > 0) begin
        chk("mem_addr", mem_addr, mq[0].addr);
        chk("mem_wdata", mem_wdata, mq[0].data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [23:0] d);
    store_en = 1'b1;
    addr_in  = a;
    ac_in    = d;
    step();
    store_en = 1'b0;
  endtask

  task automatic chk_drain(input string nm, input int n, input logic [23:0] a,
                           input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
    logic [23:0] exp [4];
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    chk({nm, "_count"}, 40'(drained.size()), 40'(n));
    for (int i = 0; i < n && i < drained.size(); i++)
      chk({nm, "_order"}, drained[i], exp[i]);
    drained.delete();
  endtask

  initial begin
    // Reset then idle, with a stray ack
    step(); step();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_wdata, 24'h0);
    mem_ack = 1'b1;
    step(); step();
    chk("idle_ack_req", mem_req, 1'b0);
    chk("idle_ack_empty", empty, 1'b1);
    mem_ack = 1'b0;

    // Single store, ack in the third request cycle
    push(16'h0010, 24'hABCDEF);
    chk("single_empty", empty, 1'b0);
    chk("single_req_lat", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_req", mem_req, 1'b1);
      chk("single_addr", mem_addr, 16'h0010);
      chk("single_wdata", mem_wdata, 24'hABCDEF);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("single_req_drop", mem_req, 1'b0);
    chk("single_empty_after", empty, 1'b1);
    chk_drain("single", 1, 24'hABCDEF, 24'h0, 24'h0, 24'h0);

    // Fill and overflow with no ack
    for (int i = 1; i <= 4; i++) push(16'(16'h0100 + i), 24'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_ovf_clear", overflow_err, 1'b0);
    push(16'h0105, 24'd5);
    chk("fill_ovf", overflow_err, 1'b1);
    mem_ack = 1'b1;
    repeat (10) step();
    mem_ack = 1'b0;
    chk("fill_empty", empty, 1'b1);
    chk("fill_ovf_sticky", overflow_err, 1'b1);
    chk_drain("fill", 4, 24'd1, 24'd2, 24'd3, 24'd4);

    // Back-to-back drain with ack tied high
    mem_ack = 1'b1;
    pat = 7'b0;
    store_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      addr_in = 16'(16'h0200 + i);
      ac_in   = 24'(24'h11 * i);
      step();
      pat = {pat[5:0], mem_req};
    end
    store_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      pat = {pat[5:0], mem_req};
    end
    chk("b2b_pattern", pat, 7'b0101010);
    chk("b2b_empty", empty, 1'b1);
    mem_ack = 1'b0;
    chk_drain("b2b", 3, 24'h11, 24'h22, 24'h33, 24'h0);

    // Push and ack on the same edge at count=2
    store_en = 1'b1;
    addr_in = 16'h0301; ac_in = 24'hA1; step();
    addr_in = 16'h0302; ac_in = 24'hB2; step();
    chk("sim2_req", mem_req, 1'b1);
    addr_in = 16'h0303; ac_in = 24'hC3; mem_ack = 1'b1; step();
    store_en = 1'b0; mem_ack = 1'b0;
    chk("sim2_full", full, 1'b0);
    chk("sim2_empty", empty, 1'b0);
    mem_ack = 1'b1;
    repeat (8) step();
    mem_ack = 1'b0;
    chk_drain("sim2", 3, 24'hA1, 24'hB2, 24'hC3, 24'h0);

    // Reset mid-request, with a store during the reset cycle
    for (int i = 1; i <= 3; i++) push(16'(16'h0400 + i), 24'(24'h50 + i));
    chk("rstmid_req", mem_req, 1'b1);
    rst = 1'b1; store_en = 1'b1; ac_in = 24'h5F; addr_in = 16'h04FF;
    step();
    rst = 1'b0; store_en = 1'b0;
    chk("rstmid_req_low", mem_req, 1'b0);
    chk("rstmid_empty", empty, 1'b1);
    chk("rstmid_ovf", overflow_err, 1'b0);
    drained.delete();
    push(16'h0077, 24'h777777);
    mem_ack = 1'b1;
    repeat (6) step();
    mem_ack = 1'b0;
    chk("rstmid_empty_after", empty, 1'b1);
    chk_drain("rstmid", 1, 24'h777777, 24'h0, 24'h0, 24'h0);

    // Push and ack on the same edge while full
    for (int i = 1; i <= 4; i++) push(16'(16'h0500 + i), 24'(24'h60 + i));
    chk("fullack_full", full, 1'b1);
    chk("fullack_req", mem_req, 1'b1);
    store_en = 1'b1; addr_in = 16'h0505; ac_in = 24'h65; mem_ack = 1'b1;
    step();
    store_en = 1'b0;
    chk("fullack_ovf", overflow_err, 1'b1);
    chk("fullack_notfull", full, 1'b0);
    repeat (10) step();
    mem_ack = 1'b0;
    chk("fullack_empty", empty, 1'b1);
    chk_drain("fullack", 4, 24'h61, 24'h62, 24'h63, 24'h64);

    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ac_store_buffer.md
# ac_store_buffer

Write-back buffer on the read side of the accumulator register. The control unit pulses a store command; the block captures the current 24-bit AC value and its target address into a small FIFO. It then drains entries to data memory over a req/ack handshake, so the datapath never stalls on memory latency unless the buffer is full.

## Interface
- WORD_SIZE, 24, width of AC data and memory write data
- ADDR_WIDTH, 16, width of data-memory address
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset; synchronous, active-high; clears all state on the clocked edge
- store_en  input  1  one-cycle store command from control unit
- ac_in  input  WORD_SIZE  current AC value (AC register output)
- addr_in  input  ADDR_WIDTH  store address (address register output)
- full  output  1  registered; count == DEPTH
- empty  output  1  registered; count == 0
- overflow_err  output  1  sticky; store_en arrived while full
- mem_req  output  1  write request to data memory
- mem_addr  output  ADDR_WIDTH  head-entry address, valid while mem_req
- mem_wdata  output  WORD_SIZE  head-entry data, valid while mem_req
- mem_ack  input  1  memory accepted the write; sampled only while mem_req=1

## Operation
- Reset values: full=0, empty=1, overflow_err=0, mem_req=0, mem_addr=0, mem_wdata=0; pointers, count =0; FSM=IDLE.
- Push: on an edge with store_en=1 and full=0, write {addr_in, ac_in} at wr_ptr; wr_ptr += 1 mod DEPTH.
- Push while full (decided on the registered full flag, even if a pop happens on the same edge): entry dropped, overflow_err set to 1. It stays set until rst.
- Pop: on an edge with mem_req=1 and mem_ack=1, rd_ptr += 1 mod DEPTH.
- Push and pop on the same edge with full=0: both happen and count is unchanged. Count is log2(DEPTH)+1 bits.
- FSM:
  - IDLE: mem_req=0. Goes to REQ on the next edge if empty=0.
  - REQ: mem_req=1. mem_addr and mem_wdata come from registered head-entry outputs, held stable until ack. On mem_ack=1, pop and go to GAP.
  - GAP: mem_req=0 for exactly one cycle, then REQ if count after the pop is nonzero, else IDLE.
- mem_ack while mem_req=0 is ignored, with no state change.
- No arithmetic on data; the value is passed through bit-exact.

## Timing
- Push at edge N: empty=0 after edge N; FSM enters REQ at edge N+1, so mem_req is high from N+1.
- Push-to-request latency is 1 cycle when IDLE. While draining, a new entry waits its FIFO turn.
- Ack sampled at edge M: mem_req low after M, high again after M+1 if entries remain. Sustained throughput is one write per 2 cycles with zero-wait memory.
- mem_req is never withdrawn without an ack except by rst.
- rst mid-transaction: mem_req=0 after the reset edge. Pending entries and the in-flight write are discarded, and the memory side must tolerate an abandoned request.
- store_en during a rst cycle is ignored.

## Structure
- Shared package ac_pkg:
  - WORD_SIZE, ADDR_WIDTH, DEPTH defaults
  - drain-FSM state enum {IDLE, REQ, GAP}
  - store-entry struct {addr, data}
- Sub-module ac_store_fifo: storage, pointers, count, full/empty, with push/pop ports and a registered head output.
- Top-level ac_store_buffer holds the FSM, the overflow flag, and the memory-port registers.

## Test plan
- Reset then idle: with rst=1 for 2 cycles, empty=1, full=0, mem_req=0, overflow_err=0. mem_ack=1 while idle causes no change.
- Single store: ac_in=24'hABCDEF, addr_in=16'h0010, store_en for 1 cycle, ack held until the 3rd cycle of request.
  - mem_req rises 1 cycle after the push and holds mem_addr=0010 and mem_wdata=ABCDEF stable through ack.
  - After the ack, empty=1.
- Fill and overflow with no ack: push 4 entries (data 1,2,3,4), then a 5th (data 5).
  - full=1 after the 4th push and overflow_err=1 after the 5th.
  - Drain order is 1,2,3,4; value 5 never appears.
- Back-to-back drain with mem_ack tied high and 3 entries: mem_req pattern is 1,0,1,0,1,0. empty=1 after the last ack.
- Simultaneous events:
  - At count=2, push plus ack on the same edge leaves count at 2 and keeps FIFO order.
  - When full, push plus ack drops the push and sets overflow_err.
- Reset mid-request: assert rst while mem_req=1 with 3 entries queued.
  - The next cycle shows mem_req=0, empty=1, overflow_err=0.
  - A subsequent store drains correctly.
